// File: rtl/CellProcessingPkg.sv
// CellProcessingPkg: shared types and defaults for the cell processor family.
// Holds the legacy single-pixel definitions plus the opcode enum, the default
// parameter set of the pipelined multi-lane processor and a per-lane cell type.
package CellProcessingPkg;

  localparam int cellDepth   = 9;
  localparam int opCodeWidth = 3;
  typedef logic [7:0] pixel_t;

  localparam int PIXEL_W_DEF     = 8;
  localparam int CELL_PIXELS_DEF = 9;
  localparam int LANES_DEF       = 2;
  localparam int OPCODE_W_DEF    = 3;
  localparam int CNT_W_DEF       = 16;

  typedef enum logic [2:0] {
    OP_ADD     = 3'd0,
    OP_ABSDIFF = 3'd1,
    OP_AVG     = 3'd2,
    OP_MAX     = 3'd3,
    OP_MIN     = 3'd4,
    OP_THRESH  = 3'd5,
    OP_BLEND   = 3'd6,
    OP_PASS    = 3'd7
  } cellOp_e;

  typedef pixel_t [CELL_PIXELS_DEF-1:0] cellLane_t;

endpackage

// File: rtl/cell_lane_alu.sv
// cell_lane_alu: one lane of the cell processor. S1 captures the centre
// operands, the decoded opcode, the 3x3 max/min reduction and (when
// CELL_PROC_BLEND_EN is defined) the two blend products; S2 selects and
// registers the lane result. Both stages advance together on adv_i.
module cell_lane_alu
  import CellProcessingPkg::*;
#(
  parameter int PIXEL_W     = PIXEL_W_DEF,
  parameter int CELL_PIXELS = CELL_PIXELS_DEF,
  parameter int OPCODE_W    = OPCODE_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           adv_i,
  input  logic [OPCODE_W-1:0]            op_i,
  input  logic [PIXEL_W-1:0]             user_i,
  input  logic [CELL_PIXELS*PIXEL_W-1:0] cell_a_i,
  input  logic [PIXEL_W-1:0]             bc_i,
  output logic [PIXEL_W-1:0]             pix_o
);

  localparam int CTR = CELL_PIXELS / 2;
  typedef logic [PIXEL_W-1:0] pix_t;
  localparam pix_t MAXV = '1;

  function automatic pix_t sat_add(pix_t a, pix_t b);
    logic [PIXEL_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[PIXEL_W] ? MAXV : s[PIXEL_W-1:0];
  endfunction

  function automatic pix_t rnd_avg(pix_t a, pix_t b);
    logic [PIXEL_W:0] s;
    s = {1'b0, a} + {1'b0, b} + (PIXEL_W+1)'(1);
    return pix_t'(s >> 1);
  endfunction

  function automatic pix_t abs_diff(pix_t a, pix_t b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

`ifdef CELL_PROC_BLEND_EN
  function automatic pix_t blend_rnd(logic [2*PIXEL_W-1:0] pa, logic [2*PIXEL_W-1:0] pb);
    logic [2*PIXEL_W:0] s;
    s = {1'b0, pa} + {1'b0, pb} + ((2*PIXEL_W+1)'(1) << (PIXEL_W - 1));
    return pix_t'(s >> PIXEL_W);
  endfunction
`endif

  pix_t    ac_p0;
  pix_t    mx_d, mn_d;
  pix_t    ac_p1_q, bc_p1_q, user_p1_q, mx_p1_q, mn_p1_q;
  cellOp_e op_p1_q;
  pix_t    res_d, res_p2_q;

  assign ac_p0 = cell_a_i[CTR*PIXEL_W +: PIXEL_W];

  // Max/min reduction over every pixel of cellA, ahead of the S1 register.
  always_comb begin
    pix_t px;
    mx_d = cell_a_i[0 +: PIXEL_W];
    mn_d = cell_a_i[0 +: PIXEL_W];
    px   = '0;
    for (int i = 1; i < CELL_PIXELS; i++) begin
      px = cell_a_i[i*PIXEL_W +: PIXEL_W];
      if (px > mx_d) mx_d = px;
      if (px < mn_d) mn_d = px;
    end
  end

  // ---- S0 -> S1 boundary: operands, decoded opcode, reduction results ----
  always_ff @(posedge clk) begin
    if (adv_i) begin
      ac_p1_q   <= ac_p0;
      bc_p1_q   <= bc_i;
      user_p1_q <= user_i;
      mx_p1_q   <= mx_d;
      mn_p1_q   <= mn_d;
      op_p1_q   <= ((op_i >> 3) != '0) ? OP_PASS : cellOp_e'(op_i[2:0]);
    end
  end

`ifdef CELL_PROC_BLEND_EN
  logic [2*PIXEL_W-1:0] pa_p1_q, pb_p1_q;

  // Blend products registered in S1 so S2 only adds and rounds.
  always_ff @(posedge clk) begin
    if (adv_i) begin
      pa_p1_q <= {{PIXEL_W{1'b0}}, ac_p0} * {{PIXEL_W{1'b0}}, user_i};
      pb_p1_q <= {{PIXEL_W{1'b0}}, bc_i} * {{PIXEL_W{1'b0}}, pix_t'(MAXV - user_i)};
    end
  end
`endif

  // Result select from the S1 contents; unknown/blend-disabled ops pass Ac.
  always_comb begin
    res_d = ac_p1_q;
    case (op_p1_q)
      OP_ADD:     res_d = sat_add(ac_p1_q, bc_p1_q);
      OP_ABSDIFF: res_d = abs_diff(ac_p1_q, bc_p1_q);
      OP_AVG:     res_d = rnd_avg(ac_p1_q, bc_p1_q);
      OP_MAX:     res_d = mx_p1_q;
      OP_MIN:     res_d = mn_p1_q;
      OP_THRESH:  res_d = (ac_p1_q >= user_p1_q) ? MAXV : '0;
`ifdef CELL_PROC_BLEND_EN
      OP_BLEND:   res_d = blend_rnd(pa_p1_q, pb_p1_q);
`endif
      default:    res_d = ac_p1_q;
    endcase
  end

  // ---- S1 -> S2 boundary: lane result, cleared by reset ----
  always_ff @(posedge clk) begin
    if (rst) begin
      res_p2_q <= '0;
    end else if (adv_i) begin
      res_p2_q <= res_d;
    end
  end

  assign pix_o = res_p2_q;

endmodule

// File: rtl/cell_processor_pipe.sv
// cell_processor_pipe: two-stage, LANES-wide cell processor with valid/ready
// handshake on both sides and a wrapping count of consumed output beats.
// Optional feature macro: CELL_PROC_BLEND_EN enables the BLEND opcode.
module cell_processor_pipe
  import CellProcessingPkg::*;
#(
  parameter int PIXEL_W     = PIXEL_W_DEF,
  parameter int CELL_PIXELS = CELL_PIXELS_DEF,
  parameter int LANES       = LANES_DEF,
  parameter int OPCODE_W    = OPCODE_W_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [LANES*CELL_PIXELS*PIXEL_W-1:0] cellA,
  input  logic [LANES*CELL_PIXELS*PIXEL_W-1:0] cellB,
  input  logic [PIXEL_W-1:0]                   userInput,
  input  logic [OPCODE_W-1:0]                  opcode,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [LANES*PIXEL_W-1:0]             processedPixel,
  output logic [CNT_W-1:0]                     beat_count
);

  localparam int LANE_W = CELL_PIXELS * PIXEL_W;
  localparam int CTR    = CELL_PIXELS / 2;

  logic             advance;
  logic             vld_p1_q, vld_p2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             unused_cellb;

  // Only the centre pixel of each cellB lane feeds the datapath.
  assign unused_cellb = ^cellB;

  assign advance   = !vld_p2_q || out_ready;
  assign in_ready  = advance && !rst;
  assign out_valid = vld_p2_q;

  // ---- S0 -> S1 -> S2 boundaries: valid bits move with the data ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else if (advance) begin
      vld_p1_q <= in_valid;
      vld_p2_q <= vld_p1_q;
    end
  end

  assign cnt_d = (vld_p2_q && out_ready) ? cnt_q + CNT_W'(1) : cnt_q;

  // Output beat counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign beat_count = cnt_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    cell_lane_alu #(
      .PIXEL_W    (PIXEL_W),
      .CELL_PIXELS(CELL_PIXELS),
      .OPCODE_W   (OPCODE_W)
    ) u_alu (
      .clk     (clk),
      .rst     (rst),
      .adv_i   (advance),
      .op_i    (opcode),
      .user_i  (userInput),
      .cell_a_i(cellA[l*LANE_W +: LANE_W]),
      .bc_i    (cellB[(l*CELL_PIXELS + CTR)*PIXEL_W +: PIXEL_W]),
      .pix_o   (processedPixel[l*PIXEL_W +: PIXEL_W])
    );
  end

endmodule

// File: tb/tb_cell_processor_pipe.sv
// tb_cell_processor_pipe: directed and random stimulus for cell_processor_pipe
// scored against an arithmetic reference of the opcode rules (CNT_W=4 so the
// beat counter wraps quickly). Honours CELL_PROC_BLEND_EN like the design.
module tb_cell_processor_pipe;

  localparam int PW = 8;
  localparam int CP = 9;
  localparam int L  = 2;
  localparam int OW = 3;
  localparam int CW = 4;

  typedef int cell_t [CP];

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic              in_ready, out_valid;
  logic [L*CP*PW-1:0] cellA = '0;
  logic [L*CP*PW-1:0] cellB = '0;
  logic [PW-1:0]     userInput = '0;
  logic [OW-1:0]     opcode = '0;
  logic [L*PW-1:0]   processedPixel;
  logic [CW-1:0]     beat_count;

  always #5 clk = ~clk;

  cell_processor_pipe #(
    .PIXEL_W(PW), .CELL_PIXELS(CP), .LANES(L), .OPCODE_W(OW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .cellA(cellA), .cellB(cellB), .userInput(userInput), .opcode(opcode),
    .out_valid(out_valid), .out_ready(out_ready),
    .processedPixel(processedPixel), .beat_count(beat_count)
  );

  cell_t a_arr [L];
  cell_t b_arr [L];
  int    op_v = 0;
  int    u_v  = 0;

  int n_chk = 0, n_err = 0;
  int cyc = 0, n_out = 0, n_acc = 0, model_cnt = 0;
  bit lat_strict = 1'b0;
  bit was_stalled = 1'b0;
  logic [L*PW-1:0] held_pix = '0;
  logic [L*PW-1:0] exp_q [$];
  int              acc_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_pix(int op, cell_t a, cell_t b, int u);
    int ac, bc, r;
    ac = a[CP/2];
    bc = b[CP/2];
    case (op)
      0: r = (ac + bc > 255) ? 255 : ac + bc;
      1: r = (ac > bc) ? ac - bc : bc - ac;
      2: r = (ac + bc + 1) / 2;
      3: begin r = a[0]; for (int i = 1; i < CP; i++) if (a[i] > r) r = a[i]; end
      4: begin r = a[0]; for (int i = 1; i < CP; i++) if (a[i] < r) r = a[i]; end
      5: r = (ac >= u) ? 255 : 0;
`ifdef CELL_PROC_BLEND_EN
      6: r = (ac * u + bc * (255 - u) + 128) / 256;
`else
      6: r = ac;
`endif
      default: r = ac;
    endcase
    return r;
  endfunction

  function automatic logic [L*PW-1:0] build_exp();
    logic [L*PW-1:0] e;
    e = '0;
    for (int l = 0; l < L; l++) e[l*PW +: PW] = PW'(ref_pix(op_v, a_arr[l], b_arr[l], u_v));
    return e;
  endfunction

  task automatic rand_beat();
    for (int l = 0; l < L; l++)
      for (int p = 0; p < CP; p++) begin
        a_arr[l][p] = int'($urandom_range(0, 255));
        b_arr[l][p] = int'($urandom_range(0, 255));
      end
    op_v = int'($urandom_range(0, 7));
    u_v  = int'($urandom_range(0, 255));
  endtask

  task automatic apply();
    for (int l = 0; l < L; l++)
      for (int p = 0; p < CP; p++) begin
        cellA[(l*CP+p)*PW +: PW] = PW'(a_arr[l][p]);
        cellB[(l*CP+p)*PW +: PW] = PW'(b_arr[l][p]);
      end
    opcode    = OW'(op_v);
    userInput = PW'(u_v);
  endtask

  // One cycle: observe just after input changes, score handshakes, step to next negedge.
  task automatic tick();
    logic [L*PW-1:0] e;
    int lat;
    #1;
    if (!rst) begin
      if (exp_q.size() == 0) chk("empty_out_valid", out_valid, 0);
      if (exp_q.size() == 0) chk("empty_in_ready", in_ready, 1);
      if (exp_q.size() == 2) chk("full_out_valid", out_valid, 1);
      if (exp_q.size() == 2 && !out_ready) chk("stall_in_ready", in_ready, 0);
      if (was_stalled) chk("hold_pixel", processedPixel, held_pix);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", out_valid, 0);
        end else begin
          e   = exp_q.pop_front();
          lat = cyc - acc_q.pop_front();
          chk("pixel", processedPixel, e);
          if (lat_strict) chk("latency", lat, 2);
          model_cnt = (model_cnt + 1) % (1 << CW);
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(build_exp());
        acc_q.push_back(cyc);
        n_acc++;
      end
      was_stalled = out_valid && !out_ready;
      held_pix    = processedPixel;
    end else begin
      was_stalled = 1'b0;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    model_cnt = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int sent;
    for (int l = 0; l < L; l++) for (int p = 0; p < CP; p++) begin a_arr[l][p] = 0; b_arr[l][p] = 0; end
    @(negedge clk);

    // Reset state
    rst = 1'b1; out_ready = 1'b1;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_pixel", processedPixel, 0);
    chk("rst_count", beat_count, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0; out_ready = 1'b0;
    #1;
    chk("idle_ready_oready_low", in_ready, 1);

    // ADD / ABSDIFF / AVG back to back, fixed 2-cycle latency
    lat_strict = 1'b1;
    out_ready  = 1'b1;
    rand_beat();
    a_arr[0][4] = 200; b_arr[0][4] = 100;
    a_arr[1][4] = 10;  b_arr[1][4] = 30;
    u_v = 0;
    for (int op = 0; op < 3; op++) begin
      op_v = op; apply(); in_valid = 1'b1; tick();
    end
    drain();

    // MAX / MIN over a known lane-0 cell
    a_arr[0] = '{5, 9, 1, 7, 3, 250, 4, 0, 6};
    op_v = 3; apply(); in_valid = 1'b1; tick();
    op_v = 4; apply(); tick();
    drain();

    // THRESH at the boundary
    u_v = 128; a_arr[0][4] = 128; a_arr[1][4] = 127;
    op_v = 5; apply(); in_valid = 1'b1; tick();
    drain();

    // BLEND extremes and PASS
    for (int l = 0; l < L; l++) begin a_arr[l][4] = 255; b_arr[l][4] = 0; end
    op_v = 6; u_v = 128; apply(); in_valid = 1'b1; tick();
    u_v = 255; apply(); tick();
    op_v = 7; apply(); tick();
    drain();
    chk("directed_outputs", n_out, 9);
    lat_strict = 1'b0;

    // Random traffic with random backpressure and bubbles
    for (int k = 0; k < 120; k++) begin
      rand_beat(); apply();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    drain();
    chk("random_count", beat_count, model_cnt);

    // Backpressure: 6 beats, out_ready low for stream cycles 3..5
    do_reset();
    chk("bp_start_count", beat_count, 0);
    base = n_out; sent = n_acc;
    for (int k = 0; k < 30 && (n_acc - sent) < 6; k++) begin
      out_ready = !(k >= 3 && k <= 5);
      in_valid  = 1'b1;
      rand_beat(); apply();
      tick();
    end
    chk("bp_accepted", n_acc - sent, 6);
    drain();
    chk("bp_outputs", n_out - base, 6);
    chk("bp_count", beat_count, 6);

    // Reset with two beats in flight
    out_ready = 1'b0; in_valid = 1'b1;
    rand_beat(); apply(); tick();
    rand_beat(); apply(); tick();
    chk("inflight_full", out_valid, 1);
    in_valid = 1'b0;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_rst_out_valid", out_valid, 0);
    end
    chk("post_rst_count", beat_count, 0);

    // Counter wrap: 17 beats with a 4-bit counter
    base = n_out;
    out_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      rand_beat(); apply(); in_valid = 1'b1; tick();
    end
    drain();
    chk("wrap_outputs", n_out - base, 17);
    chk("wrap_count", beat_count, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
